// File: rtl/fir_pkg.sv
// Shared sizes, FSM encoding and accumulator-to-output conversion for fir_tap_mac.
// Define FIR_SAT_EN to saturate the output; leave it undefined to wrap.
package fir_pkg;

    localparam int NUM_TAP = 10;
    localparam int DATA_W  = 3;
    localparam int COEF_W  = 4;
    localparam int OUT_W   = 8;
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int ACC_W   = DATA_W + COEF_W + $clog2(NUM_TAP);
    localparam int IDX_W   = $clog2(NUM_TAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
`endif

    function automatic logic signed [OUT_W-1:0] acc_to_out(input logic signed [ACC_W-1:0] acc);
`ifdef FIR_SAT_EN
        if (acc > OUT_MAX) begin
            return OUT_MAX[OUT_W-1:0];
        end else if (acc < OUT_MIN) begin
            return OUT_MIN[OUT_W-1:0];
        end else begin
            return acc[OUT_W-1:0];
        end
`else
        return acc[OUT_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/fir_tap_mac_if.sv
// Start/tap/coefficient request and result bus of the serial FIR MAC engine.
interface fir_tap_mac_if;
    import fir_pkg::*;

    logic                        start;
    logic [NUM_TAP*DATA_W-1:0]   tap_bus;
    logic [NUM_TAP*COEF_W-1:0]   coef_bus;
    logic                        busy;
    logic                        valid;
    logic [OUT_W-1:0]            fir_out;
    logic                        overrun;

    modport master (
        output start, tap_bus, coef_bus,
        input  busy, valid, fir_out, overrun
    );

    modport slave (
        input  start, tap_bus, coef_bus,
        output busy, valid, fir_out, overrun
    );

endinterface

// File: rtl/fir_mac_unit.sv
// Signed multiplier, clearable accumulator and registered output conversion.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     load_out,
    input  logic signed [DATA_W-1:0] tap,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [OUT_W-1:0]  fir_out
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    // Operands are sign-extended to the full product width before multiplying.
    assign prod = PROD_W'(tap) * PROD_W'(coef);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fir_out <= '0;
        end else if (load_out) begin
            fir_out <= acc_to_out(acc);
        end
    end

endmodule

// File: rtl/fir_tap_mac.sv
// Serial FIR MAC: snapshots the tap bus on start, walks one tap per cycle, strobes the sum.
// Output conversion is saturating when FIR_SAT_EN is defined, wrapping otherwise.
module fir_tap_mac
    import fir_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fir_tap_mac_if.slave bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TAP - 1);

    fir_state_t                state;
    fir_state_t                state_next;
    logic [IDX_W-1:0]          idx;
    logic [NUM_TAP*DATA_W-1:0] snap;
    logic                      snap_load;
    logic                      acc_en;
    logic                      out_load;
    logic                      overrun_set;
    logic                      valid_q;
    logic                      overrun_q;
    logic signed [DATA_W-1:0]  tap_sel;
    logic signed [COEF_W-1:0]  coef_sel;
    logic signed [OUT_W-1:0]   fir_out_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start in DONE re-arms immediately so back-to-back samples lose no cycle.
    always_comb begin
        state_next  = state;
        snap_load   = 1'b0;
        acc_en      = 1'b0;
        out_load    = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    snap_load  = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                acc_en      = 1'b1;
                overrun_set = bus.start;
                if (idx == IDX_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_load = 1'b1;
                if (bus.start) begin
                    snap_load  = 1'b1;
                    state_next = MAC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            snap      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (snap_load) begin
                snap <= bus.tap_bus;
                idx  <= '0;
            end else if (acc_en) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            valid_q   <= out_load;
            overrun_q <= overrun_set;
        end
    end

    assign tap_sel  = snap[idx*DATA_W +: DATA_W];
    assign coef_sel = bus.coef_bus[idx*COEF_W +: COEF_W];

    fir_mac_unit u_mac (
        .clk      (clk),
        .rst      (rst),
        .clear    (snap_load),
        .enable   (acc_en),
        .load_out (out_load),
        .tap      (tap_sel),
        .coef     (coef_sel),
        .fir_out  (fir_out_w)
    );

    assign bus.busy    = (state != IDLE);
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;
    assign bus.fir_out = fir_out_w;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed bench for fir_tap_mac: vector table plus overrun, back-to-back and reset-abort sequences.
module tb_fir_tap_mac;
    import fir_pkg::*;

    typedef struct {
        string      name;
        int         tap[NUM_TAP];
        int         coef[NUM_TAP];
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[NVEC];

    fir_tap_mac_if bus ();

    fir_tap_mac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_buses(input vec_t v);
        for (int k = 0; k < NUM_TAP; k++) begin
            bus.tap_bus[k*DATA_W +: DATA_W]  = DATA_W'(v.tap[k]);
            bus.coef_bus[k*COEF_W +: COEF_W] = COEF_W'(v.coef[k]);
        end
    endtask

    // Pulses start for one cycle; returns at the first negedge after the accepting edge.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        load_buses(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        int         lat;
        int         busy_cnt;
        int         valid_cnt;
        logic [7:0] res;
        apply_stimulus(v);
        lat       = -1;
        busy_cnt  = 0;
        valid_cnt = 0;
        res       = 8'h00;
        for (int n = 0; n < 30; n++) begin
            if (bus.busy) busy_cnt++;
            if (bus.valid) begin
                valid_cnt++;
                if (lat < 0) begin
                    lat = n;
                    res = bus.fir_out;
                end
            end
            @(negedge clk);
        end
        check_output({v.name, " result"}, int'(res), int'(v.exp));
        check_output({v.name, " latency"}, lat, 11);
        check_output({v.name, " busy cycles"}, busy_cnt, 11);
        check_output({v.name, " valid count"}, valid_cnt, 1);
        check_output({v.name, " output hold"}, int'(bus.fir_out), int'(v.exp));
    endtask

    initial begin
        vec_t a;
        vec_t b;
        int   lat1;
        int   lat2;
        int   ov_at;
        int   ov_cnt;
        int   valid_cnt;
        int   busy_cnt;
        logic [7:0] r1;
        logic [7:0] r2;

        checks = 0;
        errors = 0;

        vecs[0].name = "ones";
        vecs[0].tap  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        vecs[0].coef = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        vecs[0].exp  = 8'd10;

        vecs[1].name = "impulse";
        vecs[1].tap  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[1].coef = '{1, 1, 1, -5, 1, 1, 1, 1, 1, 1};
        vecs[1].exp  = 8'hFB;

        vecs[2].name = "neg_extreme";
        vecs[2].tap  = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4};
        vecs[2].coef = '{-8, -8, -8, -8, -8, -8, -8, -8, -8, -8};
`ifdef FIR_SAT_EN
        vecs[2].exp  = 8'd127;
`else
        vecs[2].exp  = 8'd64;
`endif

        vecs[3].name = "pos_over";
        vecs[3].tap  = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        vecs[3].coef = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
`ifdef FIR_SAT_EN
        vecs[3].exp  = 8'h7F;
`else
        vecs[3].exp  = 8'hD2;
`endif

        vecs[4].name = "neg_under";
        vecs[4].tap  = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4};
        vecs[4].coef = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
`ifdef FIR_SAT_EN
        vecs[4].exp  = 8'h80;
`else
        vecs[4].exp  = 8'hE8;
`endif

        vecs[5].name = "zero";
        vecs[5].tap  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].coef = '{3, -2, 5, 7, -8, 1, 2, 3, 4, 5};
        vecs[5].exp  = 8'h00;

        vecs[6].name = "mixed";
        vecs[6].tap  = '{1, -1, 2, -2, 3, -3, 0, 1, -4, 2};
        vecs[6].coef = '{2, 3, -1, 4, -8, 7, 5, -6, 1, 0};
        vecs[6].exp  = 8'hBE;

        bus.start    = 1'b0;
        bus.tap_bus  = '0;
        bus.coef_bus = '0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset busy", int'(bus.busy), 0);
        check_output("reset valid", int'(bus.valid), 0);
        check_output("reset overrun", int'(bus.overrun), 0);
        check_output("reset fir_out", int'(bus.fir_out), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_vector(vecs[i]);
        end

        // Second start at edge 4 must only raise overrun; new taps must be ignored.
        a = vecs[0];
        b = vecs[5];
        apply_stimulus(a);
        lat1      = -1;
        ov_at     = -1;
        ov_cnt    = 0;
        valid_cnt = 0;
        r1        = 8'h00;
        for (int n = 0; n < 30; n++) begin
            if (bus.overrun) begin
                ov_cnt++;
                if (ov_at < 0) ov_at = n;
            end
            if (bus.valid) begin
                valid_cnt++;
                if (lat1 < 0) begin
                    lat1 = n;
                    r1   = bus.fir_out;
                end
            end
            @(negedge clk);
            if (n == 2) begin
                load_buses(b);
                bus.coef_bus = '0;
                load_buses(a);
                for (int k = 0; k < NUM_TAP; k++) bus.tap_bus[k*DATA_W +: DATA_W] = 3'd0;
                bus.start = 1'b1;
            end else if (n == 3) begin
                bus.start = 1'b0;
            end
        end
        check_output("overrun position", ov_at, 4);
        check_output("overrun width", ov_cnt, 1);
        check_output("overrun result", int'(r1), 10);
        check_output("overrun latency", lat1, 11);
        check_output("overrun valid count", valid_cnt, 1);

        // Back-to-back: restart in the DONE cycle with different taps.
        a = vecs[6];
        b = vecs[1];
        apply_stimulus(a);
        lat1      = -1;
        lat2      = -1;
        busy_cnt  = 0;
        valid_cnt = 0;
        r1        = 8'h00;
        r2        = 8'h00;
        for (int n = 0; n < 40; n++) begin
            if (bus.busy) busy_cnt++;
            if (bus.valid) begin
                valid_cnt++;
                if (lat1 < 0) begin
                    lat1 = n;
                    r1   = bus.fir_out;
                end else if (lat2 < 0) begin
                    lat2 = n;
                    r2   = bus.fir_out;
                end
            end
            if (n == 10) begin
                load_buses(b);
                bus.start = 1'b1;
            end else if (n == 11) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check_output("b2b first result", int'(r1), int'(a.exp));
        check_output("b2b second result", int'(r2), int'(b.exp));
        check_output("b2b first latency", lat1, 11);
        check_output("b2b second latency", lat2, 22);
        check_output("b2b valid count", valid_cnt, 2);
        check_output("b2b busy cycles", busy_cnt, 22);

        // Asynchronous reset in the middle of MAC aborts without a result.
        apply_stimulus(vecs[0]);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("abort busy", int'(bus.busy), 0);
        check_output("abort valid", int'(bus.valid), 0);
        check_output("abort overrun", int'(bus.overrun), 0);
        check_output("abort fir_out", int'(bus.fir_out), 0);
        @(negedge clk);
        rst       = 1'b0;
        valid_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.valid) valid_cnt++;
            @(negedge clk);
        end
        check_output("abort no valid", valid_cnt, 0);
        run_vector(vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
